// File: rtl/bsg_chip_pkg.sv
// Shared chip-level definitions for the link reset sequencing logic.
package bsg_chip_pkg;

  // Default width of the per-phase wait count for link reset sequencing.
  localparam int bsg_link_reset_wait_width_gp = 8;

  // Link reset sequencer phases.
  typedef enum logic [2:0] {
    e_link_rst_idle   = 3'd0,
    e_link_rst_assert = 3'd1,
    e_link_rst_up     = 3'd2,
    e_link_rst_down   = 3'd3,
    e_link_rst_core   = 3'd4,
    e_link_rst_done   = 3'd5
  } bsg_link_reset_state_e;

endpackage

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter: set loads a value, down decrements and stops at zero.
module bsg_counter_set_down #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_i,
  input  logic [width_p-1:0] val_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_r_o
);

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      count_r_o <= '0;
    else if (set_i)
      count_r_o <= val_i;
    else if (down_i && (count_r_o != '0))
      count_r_o <= count_r_o - 1'b1;
  end

endmodule

// File: rtl/bsg_chip_link_reset_sequencer.sv
// Staged reset release for a group of bsg_link channels and the core behind them.
//
// state  | meaning
// IDLE   | after reset; all resets held, waiting for a request
// ASSERT | all resets asserted for W+1 cycles
// UP     | upstream resets of enabled links released
// DOWN   | downstream resets of enabled links released
// CORE   | core reset released
// DONE   | sequence complete; a new request restarts it
module bsg_chip_link_reset_sequencer
  import bsg_chip_pkg::*;
#(
  parameter int link_num_p   = 2,
  parameter int wait_width_p = bsg_link_reset_wait_width_gp
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_v_i,
  output logic                    start_ready_o,
  input  logic [wait_width_p-1:0] wait_cycles_i,
  input  logic [link_num_p-1:0]   link_en_i,
  output logic [link_num_p-1:0]   upstream_reset_o,
  output logic [link_num_p-1:0]   downstream_reset_o,
  output logic                    core_reset_o,
  output logic                    busy_o,
  output logic                    done_o
);

  bsg_link_reset_state_e   state_r;
  logic [wait_width_p-1:0] wait_r;
  logic [link_num_p-1:0]   mask_r;
  logic [wait_width_p-1:0] count_r;
  logic                    accept;
  logic                    phase_active;
  logic                    count_zero;
  logic                    count_set;
  logic [wait_width_p-1:0] count_val;

  // Ready is a pure state decode so no input can reach it combinationally.
  assign start_ready_o = (state_r == e_link_rst_idle) || (state_r == e_link_rst_done);
  assign accept        = start_v_i & start_ready_o;
  assign phase_active  = (state_r == e_link_rst_assert) || (state_r == e_link_rst_up)
                      || (state_r == e_link_rst_down)   || (state_r == e_link_rst_core);
  assign count_zero    = (count_r == '0);

  // Reload with W on accept and on every phase boundary so each phase lasts W+1 cycles.
  assign count_set = accept | (phase_active & count_zero);
  assign count_val = accept ? wait_cycles_i : wait_r;

  bsg_counter_set_down #(
    .width_p (wait_width_p)
  ) phase_counter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .set_i     (count_set),
    .val_i     (count_val),
    .down_i    (phase_active),
    .count_r_o (count_r)
  );

  // Sequencer state and registered reset/status outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r            <= e_link_rst_idle;
      wait_r             <= '0;
      mask_r             <= '0;
      upstream_reset_o   <= '1;
      downstream_reset_o <= '1;
      core_reset_o       <= 1'b1;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
    end else begin
      case (state_r)
        e_link_rst_idle, e_link_rst_done: begin
          if (accept) begin
            state_r            <= e_link_rst_assert;
            wait_r             <= wait_cycles_i;
            mask_r             <= link_en_i;
            upstream_reset_o   <= '1;
            downstream_reset_o <= '1;
            core_reset_o       <= 1'b1;
            busy_o             <= 1'b1;
            done_o             <= 1'b0;
          end
        end
        e_link_rst_assert: begin
          if (count_zero) begin
            state_r          <= e_link_rst_up;
            upstream_reset_o <= ~mask_r;
          end
        end
        e_link_rst_up: begin
          if (count_zero) begin
            state_r            <= e_link_rst_down;
            downstream_reset_o <= ~mask_r;
          end
        end
        e_link_rst_down: begin
          if (count_zero) begin
            state_r      <= e_link_rst_core;
            core_reset_o <= 1'b0;
          end
        end
        e_link_rst_core: begin
          if (count_zero) begin
            state_r <= e_link_rst_done;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        default: begin
          state_r <= e_link_rst_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_chip_link_reset_sequencer.sv
// Bench for the link reset sequencer: directed scenarios plus random traffic,
// checked every cycle against a cycle-count model of the release schedule.
module tb_bsg_chip_link_reset_sequencer;

  localparam int LN = 2;
  localparam int WW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          start_v_i;
  logic          start_ready_o;
  logic [WW-1:0] wait_cycles_i;
  logic [LN-1:0] link_en_i;
  logic [LN-1:0] upstream_reset_o;
  logic [LN-1:0] downstream_reset_o;
  logic          core_reset_o;
  logic          busy_o;
  logic          done_o;

  int compared   = 0;
  int mismatched = 0;

  // Model: t = cycles since the accepting edge (0 = nothing accepted since reset).
  int          t  = 0;
  int          mw = 0;
  logic [LN-1:0] mm = '0;

  bsg_chip_link_reset_sequencer #(
    .link_num_p   (LN),
    .wait_width_p (WW)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .start_v_i          (start_v_i),
    .start_ready_o      (start_ready_o),
    .wait_cycles_i      (wait_cycles_i),
    .link_en_i          (link_en_i),
    .upstream_reset_o   (upstream_reset_o),
    .downstream_reset_o (downstream_reset_o),
    .core_reset_o       (core_reset_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d W=%0d mask=%0b)", tag, obs, exp, t, mw, mm);
    end
  endtask

  // Expected outputs follow directly from the phase boundaries W+2, 2W+3, 3W+4, 4W+5.
  task automatic check();
    logic [LN-1:0] eu, ed;
    logic ec, eb, edn;
    eu = '1; ed = '1; ec = 1'b1; eb = 1'b0; edn = 1'b0;
    if (t > 0) begin
      if (t <= 4*mw + 4) eb = 1'b1; else edn = 1'b1;
      if (t >= mw + 2)   eu = ~mm;
      if (t >= 2*mw + 3) ed = ~mm;
      if (t >= 3*mw + 4) ec = 1'b0;
    end
    cmp("upstream_reset",   32'(upstream_reset_o),   32'(eu));
    cmp("downstream_reset", 32'(downstream_reset_o), 32'(ed));
    cmp("core_reset",       32'(core_reset_o),       32'(ec));
    cmp("busy",             32'(busy_o),             32'(eb));
    cmp("done",             32'(done_o),             32'(edn));
    cmp("start_ready",      32'(start_ready_o),      32'(!eb));
  endtask

  task automatic tick();
    bit m_ready;
    @(posedge clk_i);
    m_ready = (t == 0) || (t >= 4*mw + 5);
    if (start_v_i && m_ready) begin
      mw = int'(wait_cycles_i);
      mm = link_en_i;
      t  = 1;
    end else if (t > 0 && t < 1000000) begin
      t++;
    end
    @(negedge clk_i);
    check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_pulse(input int w, input logic [LN-1:0] m);
    start_v_i     = 1'b1;
    wait_cycles_i = WW'(w);
    link_en_i     = m;
    tick();
    start_v_i     = 1'b0;
    wait_cycles_i = WW'($urandom);
    link_en_i     = LN'($urandom);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must respond without an edge.
  task automatic pulse_reset();
    reset_i = 1'b1;
    #1;
    t = 0;
    check();
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i       = 1'b1;
    start_v_i     = 1'b0;
    wait_cycles_i = '0;
    link_en_i     = '0;
    @(negedge clk_i);
    check();
    reset_i = 1'b0;
    run(3);

    // W=2, both links: up at 4, down at 7, core at 10, done at 13.
    start_pulse(2, 2'b11);
    run(16);

    // W=0, link0 only.
    start_pulse(0, 2'b01);
    run(7);

    // Start held through a W=3 sequence: one sequence, then re-accept from DONE.
    start_v_i     = 1'b1;
    wait_cycles_i = 8'd3;
    link_en_i     = 2'b11;
    run(20);
    start_v_i = 1'b0;
    run(18);

    // Reset during DOWN, then a full sequence again.
    start_pulse(2, 2'b11);
    while (t < 8) tick();
    pulse_reset();
    run(2);
    start_pulse(2, 2'b10);
    run(15);

    // Empty mask still releases the core.
    start_pulse(1, 2'b00);
    run(10);

    // Maximum wait count, no wrap.
    start_pulse(255, 2'b11);
    run(1030);

    // Random requests, masks, wait counts and occasional resets.
    for (int i = 0; i < 400; i++) begin
      start_v_i     = ($urandom_range(0, 3) == 0);
      wait_cycles_i = WW'($urandom_range(0, 4));
      link_en_i     = LN'($urandom);
      if ($urandom_range(0, 79) == 0) pulse_reset();
      tick();
    end
    start_v_i = 1'b0;
    run(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
